// File: rtl/registrador_universal.sv
// registrador_universal: WIDTH-bit function-coded working register with serial in/out,
// rotates and a multi-cycle N-position shift engine with a busy/done handshake.
// Optional build macro REGISTRADOR_ARITH_SHIFT_EN: right shifts fill with dout[WIDTH-1] instead of ser_in.
module registrador_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
    input  logic             dir,
    input  logic [AMT_W-1:0] shamt,
    output logic [WIDTH-1:0] dout,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    state_t           state;
    logic [AMT_W-1:0] count;
    logic [AMT_W-1:0] amt;
    logic             dir_q;
    logic             fill;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;
    // right-shift fill bit, one-step shift candidates and the clamped SHIFTN amount
    always_comb begin
`ifdef REGISTRADOR_ARITH_SHIFT_EN
        fill = dout[WIDTH-1];
`else
        fill = ser_in;
`endif
        shr = {fill, dout[WIDTH-1:1]};
        shl = {dout[WIDTH-2:0], ser_in};
        amt = (shamt > AMT_MAX) ? AMT_MAX : shamt;
    end
    // func decode in IDLE; in SHIFT one step per edge until the counter drains, inputs ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            dout    <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            state   <= IDLE;
            count   <= '0;
            dir_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    case (func)
                        3'b001: dout <= din;
                        3'b010: begin
                            dout    <= shr;
                            ser_out <= dout[0];
                        end
                        3'b011: begin
                            dout    <= shl;
                            ser_out <= dout[WIDTH-1];
                        end
                        3'b100: dout <= '0;
                        3'b101: begin
                            dout    <= {dout[0], dout[WIDTH-1:1]};
                            ser_out <= dout[0];
                        end
                        3'b110: begin
                            dout    <= {dout[WIDTH-2:0], dout[WIDTH-1]};
                            ser_out <= dout[WIDTH-1];
                        end
                        3'b111: begin
                            if (amt == '0) begin
                                done <= 1'b1;
                            end else begin
                                count <= amt;
                                dir_q <= dir;
                                busy  <= 1'b1;
                                state <= SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
                SHIFT: begin
                    dout    <= dir_q ? shl : shr;
                    ser_out <= dir_q ? dout[WIDTH-1] : dout[0];
                    count   <= count - 1'b1;
                    if (count == AMT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_registrador_universal.sv
// tb_registrador_universal: vector table, hand-written multi-cycle sequences and a random run against a reference model.
module tb_registrador_universal;
    localparam int W = 8;
`ifdef REGISTRADOR_ARITH_SHIFT_EN
    localparam bit ARITH = 1'b1;
`else
    localparam bit ARITH = 1'b0;
`endif
    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] func;
    logic [7:0] din;
    logic       ser_in;
    logic       dir;
    logic [3:0] shamt;
    logic [7:0] dout;
    logic       ser_out;
    logic       busy;
    logic       done;
    int checks = 0;
    int failures = 0;

    registrador_universal #(.WIDTH(W), .AMT_W(4)) dut (
        .clock(clock), .reset(reset), .func(func), .din(din), .ser_in(ser_in),
        .dir(dir), .shamt(shamt), .dout(dout), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       r;
        logic [2:0] f;
        logic [7:0] d;
        logic       si;
        logic       dr;
        logic [3:0] sa;
        logic [7:0] ed;
        logic       eso;
        logic       eb;
        logic       edn;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] f, input logic [7:0] d,
                        input logic si, input logic dr, input logic [3:0] sa);
        reset = r; func = f; din = d; ser_in = si; dir = dr; shamt = sa;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ed, input logic eso, input logic eb, input logic edn);
        chk({nm, ".dout"}, 32'(dout), 32'(ed));
        chk({nm, ".ser_out"}, 32'(ser_out), 32'(eso));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
        chk({nm, ".done"}, 32'(done), 32'(edn));
    endtask

    vec_t tbl[20];

    // reference model state: register value as plain integers, plus a remaining-step count
    int md, mso, mb, mdn, rem, mdir;

    task automatic model(input logic r, input logic [2:0] f, input logic [7:0] d,
                         input logic si, input logic dr, input logic [3:0] sa);
        int k;
        int fr;
        fr = ARITH ? (md >> 7) & 1 : int'(si);
        if (r) begin
            md = 0; mso = 0; mb = 0; mdn = 0; rem = 0; mdir = 0;
        end else begin
            mdn = 0;
            if (mb != 0) begin
                if (mdir != 0) begin
                    mso = (md >> 7) & 1;
                    md = (md * 2 + int'(si)) % 256;
                end else begin
                    mso = md & 1;
                    md = md / 2 + fr * 128;
                end
                rem = rem - 1;
                if (rem == 0) begin
                    mb = 0;
                    mdn = 1;
                end
            end else begin
                case (f)
                    3'd1: md = int'(d);
                    3'd2: begin mso = md & 1; md = md / 2 + fr * 128; end
                    3'd3: begin mso = (md >> 7) & 1; md = (md * 2 + int'(si)) % 256; end
                    3'd4: md = 0;
                    3'd5: begin mso = md & 1; md = md / 2 + mso * 128; end
                    3'd6: begin mso = (md >> 7) & 1; md = (md * 2) % 256 + mso; end
                    3'd7: begin
                        k = (int'(sa) > W) ? W : int'(sa);
                        if (k == 0) mdn = 1;
                        else begin rem = k; mdir = int'(dr); mb = 1; end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        int bcnt;
        int seen_done;
        logic r;
        logic [2:0] f;
        logic [7:0] d;
        logic si, dr;
        logic [3:0] sa;
        reset = 1'b1; func = '0; din = '0; ser_in = 1'b0; dir = 1'b0; shamt = '0;

        tbl[0]  = '{1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd1, 8'hA5, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 8'h3C, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 4'd0, 8'h4B, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd1, 8'h77, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd1, 8'h81, 1'b0, 1'b0, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'hC0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 4'd0, 8'h81, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h02, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'd1, 8'hF0, 1'b0, 1'b0, 4'd0, 8'hF0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'd3, 8'hF0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'd1, 8'h55, 1'b0, 1'b1, 4'd1, ARITH ? 8'hF8 : 8'h78, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 3'd1, 8'h55, 1'b0, 1'b0, 4'd0, ARITH ? 8'hFC : 8'h3C, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 3'd4, 8'h55, 1'b0, 1'b0, 4'd0, ARITH ? 8'hFE : 8'h1E, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 3'd7, 8'h00, 1'b1, 1'b1, 4'd0, ARITH ? 8'hFE : 8'h1E, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0, ARITH ? 8'hFE : 8'h1E, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 4'd0, ARITH ? 8'h00 : 8'h80, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].d, tbl[i].si, tbl[i].dr, tbl[i].sa);
            chk($sformatf("vec%0d", i), {dout, ser_out, busy, done}, {tbl[i].ed, tbl[i].eso, tbl[i].eb, tbl[i].edn});
        end

        // shamt above WIDTH clamps to WIDTH steps
        step(1'b0, 3'd1, 8'hFF, 1'b0, 1'b0, 4'd0);
        step(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'd15);
        bcnt = 0;
        seen_done = 0;
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            if (busy) bcnt++;
            if (done) seen_done = 1;
            else step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
        end
        chk("clamp.busy_cycles", 32'(bcnt), 32'd8);
        chk("clamp.done_seen", 32'(seen_done), 32'd1);
        chk("clamp.dout", 32'(dout), ARITH ? 32'hFF : 32'h00);

        // reset during the second busy cycle abandons the shift with no done pulse
        step(1'b0, 3'd1, 8'hF0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 4'd5);
        chk("rst_busy.busy1", 32'(busy), 32'd1);
        step(1'b1, 3'd1, 8'h55, 1'b1, 1'b0, 4'd0);
        chk_all("rst_busy", 8'h00, 1'b0, 1'b0, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
            if (done || busy) seen_done = 1;
        end
        chk("rst_busy.no_done", 32'(seen_done), 32'd0);

        // back-to-back SHIFTN issued on the done cycle
        step(1'b0, 3'd1, 8'h0F, 1'b0, 1'b0, 4'd0);
        step(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 4'd1);
        chk_all("b2b.accept1", 8'h0F, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
        chk_all("b2b.done1", 8'h07, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'd7, 8'h00, 1'b1, 1'b1, 4'd2);
        chk_all("b2b.accept2", 8'h07, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0);
        chk_all("b2b.step1", 8'h0F, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 4'd0);
        chk_all("b2b.done2", 8'h1F, 1'b0, 1'b0, 1'b1);

        // randomized run against the reference model
        step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
        model(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            f  = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            si = 1'($urandom);
            dr = 1'($urandom);
            sa = 4'($urandom);
            step(r, f, d, si, dr, sa);
            model(r, f, d, si, dr, sa);
            chk($sformatf("rand%0d", i), {dout, ser_out, busy, done},
                {md[7:0], mso[0], mb[0], mdn[0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
